// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial pattern detector: FSM encoding and default sizes.
package seq_detect_pkg;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_DETECT = 2'd2;
endpackage

// File: rtl/seq_shift_reg.sv
// History shift register: newest serial bit enters at the LSB, older bits move left.
module seq_shift_reg #(
    parameter int MAX_LEN = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               din,
    output logic [MAX_LEN-1:0] q
);
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[MAX_LEN-2:0], din};
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: owns the history register, a fill counter,
// the IDLE/FILL/DETECT sequencer and a saturating match counter.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         state
);
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [LEN_W-1:0]   fill_cnt;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] hist_new;
    logic [MAX_LEN-1:0] len_mask;
    logic [1:0]         next_state;
    logic               bit_en;
    logic               at_len;
    logic               armed;
    logic               hit;

    // A bit arriving alongside cfg_load belongs to the old configuration and is dropped.
    assign bit_en      = din_valid && !cfg_load;
    assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    seq_shift_reg #(.MAX_LEN(MAX_LEN)) u_hist (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .shift_en (bit_en),
        .clr      (cfg_load),
        .din      (din),
        .q        (history)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (cfg_load) begin
            next_state = (len_clamped == '0) ? ST_IDLE : ST_FILL;
        end else if (bit_en) begin
            case (state)
                ST_FILL:   if (at_len) next_state = (hit && !overlap_q) ? ST_FILL : ST_DETECT;
                ST_DETECT: if (hit && !overlap_q) next_state = ST_FILL;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Compare against the history as it will look after this bit is shifted in.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hist_new = {history[MAX_LEN-2:0], din};
        fill_inc = fill_cnt + LEN_W'(1);
        at_len   = (fill_inc == len_q);
        armed    = (state == ST_DETECT) || ((state == ST_FILL) && at_len);
        hit      = bit_en && armed && (((hist_new ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            fill_cnt    <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_clamped;
                overlap_q <= cfg_overlap;
                fill_cnt  <= '0;
            end else if (bit_en && (state != ST_IDLE)) begin
                if (hit && !overlap_q) begin
                    fill_cnt <= '0;
                end else if (fill_cnt != len_q) begin
                    fill_cnt <= fill_inc;
                end
            end
            match <= hit;
            if (clr_count) begin
                match_count <= '0;
            end else if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detector controller for the Sequence_Detector design. Samples a qualified serial bit stream and asserts a one-cycle match pulse when the last cfg_len bits equal the programmed pattern. Supports overlapping and non-overlapping detection and keeps a saturating match counter. Sequences a shift-history register that it owns; downstream logic consumes match and match_count.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (range 2..16).
LEN_W, $clog2(MAX_LEN+1), width of cfg_len.
CNT_W, 8, width of match_count.

Ports:
Clk  in  1  system clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit expected, bit [0] the last.
cfg_len  in  LEN_W  pattern length; 0 disables detection; values above MAX_LEN clamp to MAX_LEN.
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
din  in  1  serial data bit.
din_valid  in  1  din is sampled only when this is high.
clr_count  in  1  synchronous clear of match_count.
match  out  1  registered one-cycle pulse on detection.
match_count  out  CNT_W  saturating count of detections.
state  out  2  current FSM state, for debug.

Behaviour:
- Reset (Rst_n low, asynchronous): match=0, match_count=0, state=IDLE, history=0, fill count=0, latched pattern=0, len=0, overlap=0.
- The history register shifts left on every din_valid cycle; the new bit enters at the LSB. The fill counter increments on each valid bit and saturates at len.
- FSM states:
  - IDLE (2'd0): len==0. Bits are ignored and match stays 0. cfg_load with nonzero len -> FILL.
  - FILL (2'd1): fill count < len. On a valid bit, if count+1==len -> DETECT (a compare on that same bit is allowed).
  - DETECT (2'd2): on each valid bit, compare the new history[len-1:0] against pattern[len-1:0].
- Latency: a bit sampled at edge N that completes the pattern gives match=1 for the cycle after edge N. match_count increments at the same edge N.
- Overlapping mode: the history is kept after a match, and the state stays DETECT.
- Non-overlapping mode: on a match, the fill counter clears and the state -> FILL. The next match needs len fresh bits.
- din_valid low: no shift, no compare, match=0. Gaps of any length are transparent.
- cfg_load at any time:
  - the new config takes effect at the next edge;
  - history and fill count clear;
  - a bit on the same cycle is discarded;
  - the state goes to FILL, or IDLE if the new len is 0;
  - match_count is not affected.
- Clamp: cfg_len > MAX_LEN is latched as MAX_LEN.
- match_count saturates at 2^CNT_W-1. It does not wrap.
- clr_count: match_count=0 at the next edge. If a match happens on the same cycle, clr_count wins and the count is 0. The match pulse still fires.
- Reset mid-stream: all state is lost at once. The config must be reloaded after reset.

Decomposition:
- Package seq_detect_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_FILL=2'd1, ST_DETECT=2'd2;
  - the default MAX_LEN and CNT_W.
- Sub-module seq_shift_reg holds the MAX_LEN-bit history shift register. Its ports are Clk, Rst_n, shift_en, clr, din and q.
- The controller holds the FSM, the fill counter, the compare and the counter.

Test Plan:
- Overlap: pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> match after bits 4 and 7; match_count=2.
- Non-overlap: same config with overlap=0, same stream -> match after bit 4 only; match_count=1; state returns to FILL after the match.
- Valid gaps: stream 1,0,1,1 with din_valid low for 3 cycles between each bit -> exactly one match, one cycle after the 4th valid bit.
- Saturation and clear: CNT_W=8, len=2, pattern=2'b11, overlap=1, 300 consecutive 1s -> match_count holds at 255. Then clr_count together with a match -> match_count=0 and match=1.
- Mid-stream reconfig: after 3 of the bits 1,0,1,1, cfg_load pattern=3'b111, len=3 -> no match on the remaining bit. Stream 1,1,1 -> match.
- Reset and edge configs: Rst_n low mid-FILL -> match=0, count=0, state=IDLE at once, with no further matches until cfg_load. cfg_len=0 -> no matches. cfg_len=15 with MAX_LEN=8 -> behaves as len 8.
